gpu_rs232_ram_bridge: RTL and testbench
=======================================

# gpu_rs232_ram_bridge

Host-side command bridge that sits directly upstream of port B of the GPU dual-port RAM. It converts a byte stream from the RS232 receiver into RAM writes and block reads on the host port, and returns read data to the RS232 transmitter. Port A (the GPU video read path) is untouched by this block. Port B's clock must be driven from the same `clk` as this block.

## Interface
- `ADDR_W`, 20: RAM address width on port B. Upper address bits beyond the RAM's internal size are passed through unchanged.
- `RD_LATENCY`, 2: clocks from `addr_b` to valid `data_out_b`. Port B registers both the address and the output data.
- `TIMEOUT_CYCLES`, 2_500_000: maximum idle gap between bytes inside one packet before the packet is aborted.
- `clk` in 1: the single clock. It also drives RAM port B.
- `rst_n` in 1: reset. Synchronous, active-low.
- `rx_valid` in 1: one-cycle strobe; `rx_data` holds a received byte.
- `rx_data` in 8: received byte.
- `tx_data` out 8: byte to transmit.
- `tx_valid` out 1: `tx_data` is valid; held until accepted.
- `tx_ready` in 1: transmitter accepts the byte on a cycle where `tx_valid && tx_ready`.
- `addr_b` out ADDR_W: port B address.
- `data_in_b` out 8: port B write data.
- `wr_en_b` out 1: port B write enable (one cycle per byte).
- `data_out_b` in 8: port B read data.
- `busy` out 1: high whenever the state is not IDLE.
- `err` out 1: one-cycle pulse on an unknown header byte or on a timeout abort.

## Operation
- Packet format: header, ADDR[23:16], ADDR[15:8], ADDR[7:0], LEN, then payload.
  - Address bits above `ADDR_W` are discarded.
  - LEN = 0 means 256 bytes; otherwise the transfer is LEN bytes.
- Header 0x57 ('W'): LEN data bytes follow. Each received byte produces exactly one write, and the address then increments by 1.
- Header 0x52 ('R'): no payload follows. The block reads LEN bytes starting at ADDR and sends them on tx in address order.
- Any other header while in IDLE: pulse `err` and stay in IDLE. The byte is consumed.
- State machine:
  - IDLE → A2 on a valid header.
  - A2 → A1 → A0 → LEN, one state per `rx_valid`.
  - LEN → WDATA for 'W'; LEN → RREQ for 'R'.
  - WDATA: each `rx_valid` drives one write. After the last byte → IDLE.
  - RREQ: drive `addr_b`, load the wait counter with `RD_LATENCY` → RWAIT.
  - RWAIT: count down to 0, then latch `data_out_b` into `tx_data` and raise `tx_valid` → RSEND.
  - RSEND: on `tx_valid && tx_ready`, drop `tx_valid`, increment the address, decrement the count. → RREQ if bytes remain, else → IDLE.
- Address arithmetic is modulo 2^ADDR_W: 0xFFFFF + 1 wraps to 0x00000. The count register is 9 bits.
- In RREQ, RWAIT and RSEND, `rx_valid` is ignored and the byte is dropped. The host must not send until the read completes.
- Timeout: a counter is cleared on every `rx_valid` in A2..WDATA and increments every other cycle in those states. When it reaches `TIMEOUT_CYCLES`, pulse `err` and go to IDLE. The timeout does not apply in the read states.

## Timing
- Reset: state IDLE, `addr_b` = 0, `data_in_b` = 0, `wr_en_b` = 0, `tx_valid` = 0, `tx_data` = 0, `busy` = 0, `err` = 0.
  - A reset asserted mid-packet aborts immediately.
  - No partial write is issued after reset.
- Write path: `rx_valid` for a data byte in cycle N gives `wr_en_b` = 1 in cycle N+1, with `addr_b` and `data_in_b` registered. `addr_b` increments in cycle N+2. There is no back-pressure; one byte per cycle is sustained.
- Read path: `addr_b` is valid in cycle M (RREQ). `tx_valid` rises in cycle M+RD_LATENCY+1.
- Read throughput: each byte takes at least RD_LATENCY+2 cycles plus the tx handshake. Read data sampled after RD_LATENCY cycles reflects any write issued earlier on port B (old-data read-during-write semantics do not arise, since reads and writes are never concurrent).
- `tx_data` is stable while `tx_valid` is high and `tx_ready` is low.
- `err` is high for exactly one cycle per event.

## Structure
- Shared package `gpu_bridge_pkg` holds:
  - `CMD_WRITE` = 8'h57 and `CMD_READ` = 8'h52.
  - The state enum: IDLE, A2, A1, A0, LEN, WDATA, RREQ, RWAIT, RSEND.
- No sub-module is required. The timeout counter stays inline.

## Test plan
- Write packet 57 00 01 00 03 AA BB CC → three `wr_en_b` pulses at addresses 0x00100, 0x00101, 0x00102 with data AA, BB, CC. Then `busy` = 0.
- Read packet 52 00 01 00 03 after the previous write, with `tx_ready` held low for 5 cycles per byte → tx emits AA, BB, CC in order, and `tx_data` is stable while stalled.
- Write 57 0F FF FF 02 11 22 → writes to 0xFFFFF, then 0x00000 (wrap). LEN = 00 on a read → exactly 256 tx bytes.
- Header 0x41 → `err` pulses once and the state remains IDLE. The next valid 'W' packet executes normally.
- Send 57 00 00 then go silent for `TIMEOUT_CYCLES` → `err` pulses and the state returns to IDLE with no `wr_en_b`. A following packet works.
- Assert `rst_n` = 0 during WDATA after 1 of 4 bytes → all outputs hold reset values on the next cycle. A new packet after release executes from IDLE.

Source files
------------

// File: rtl/gpu_rs232_ram_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module  : gpu_bridge_pkg
// Purpose : Command codes, state encoding and length helper for the RS232 bridge.
// Revision: 1.0 - initial release
// ============================================================================
package gpu_bridge_pkg;

    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_READ  = 8'h52;

    typedef enum logic [3:0] {
        IDLE  = 4'd0,
        A2    = 4'd1,
        A1    = 4'd2,
        A0    = 4'd3,
        LEN   = 4'd4,
        WDATA = 4'd5,
        RREQ  = 4'd6,
        RWAIT = 4'd7,
        RSEND = 4'd8
    } state_t;

    // A LEN byte of zero encodes a full 256-byte transfer.
    function automatic logic [8:0] len_to_count(input logic [7:0] len);
        return (len == 8'd0) ? 9'd256 : {1'b0, len};
    endfunction

endpackage
`default_nettype wire

// File: rtl/gpu_rs232_ram_bridge_if.sv
`default_nettype none
// ============================================================================
// Module  : gpu_rs232_ram_bridge_if
// Purpose : RS232 rx/tx byte streams plus RAM port B, as seen by the bridge.
// Revision: 1.0 - initial release
// ============================================================================
interface gpu_rs232_ram_bridge_if #(
    parameter int ADDR_W = 20
) ();
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [ADDR_W-1:0] addr_b;
    logic [7:0]        data_in_b;
    logic              wr_en_b;
    logic [7:0]        data_out_b;

    modport master (
        input  rx_valid, rx_data, tx_ready, data_out_b,
        output tx_data, tx_valid, addr_b, data_in_b, wr_en_b
    );

    modport slave (
        output rx_valid, rx_data, tx_ready, data_out_b,
        input  tx_data, tx_valid, addr_b, data_in_b, wr_en_b
    );
endinterface
`default_nettype wire

// File: rtl/gpu_rs232_ram_bridge.sv
`default_nettype none
// ============================================================================
// Module  : gpu_rs232_ram_bridge
// Purpose : Turns RS232 command packets into RAM port-B writes and block reads.
// Revision: 1.0 - initial release
// ============================================================================
module gpu_rs232_ram_bridge
    import gpu_bridge_pkg::*;
#(
    parameter int ADDR_W         = 20,
    parameter int RD_LATENCY     = 2,
    parameter int TIMEOUT_CYCLES = 2_500_000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    gpu_rs232_ram_bridge_if.master        bus,
    output logic                          busy,
    output logic                          err
);

    localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam int WAIT_W = $clog2(RD_LATENCY + 2);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(RD_LATENCY);

    state_t              state_q,     state_d;
    logic [ADDR_W-1:0]   addr_q,      addr_d;
    logic [8:0]          cnt_q,       cnt_d;
    logic                is_read_q,   is_read_d;
    logic [WAIT_W-1:0]   wait_q,      wait_d;
    logic [TO_W-1:0]     to_q,        to_d;
    logic [7:0]          tx_data_q,   tx_data_d;
    logic                tx_valid_q,  tx_valid_d;
    logic [7:0]          data_in_q,   data_in_d;
    logic                wr_en_q,     wr_en_d;
    logic                err_q,       err_d;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        is_read_d  = is_read_q;
        wait_d     = wait_q;
        to_d       = '0;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        data_in_d  = data_in_q;
        wr_en_d    = 1'b0;
        err_d      = 1'b0;

        // The write address advances the cycle after its write strobe.
        if (wr_en_q) begin
            addr_d = addr_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (bus.rx_valid) begin
                    if (bus.rx_data == CMD_WRITE || bus.rx_data == CMD_READ) begin
                        is_read_d = (bus.rx_data == CMD_READ);
                        addr_d    = '0;
                        state_d   = A2;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            A2, A1, A0, LEN, WDATA: begin
                if (bus.rx_valid) begin
                    if (state_q == A2 || state_q == A1 || state_q == A0) begin
                        // Shifting in 24 address bits leaves only the low ADDR_W.
                        addr_d  = {addr_q[ADDR_W-9:0], bus.rx_data};
                        state_d = (state_q == A2) ? A1 : (state_q == A1) ? A0 : LEN;
                    end else if (state_q == LEN) begin
                        cnt_d   = len_to_count(bus.rx_data);
                        state_d = is_read_q ? RREQ : WDATA;
                    end else begin
                        data_in_d = bus.rx_data;
                        wr_en_d   = 1'b1;
                        cnt_d     = cnt_q - 9'd1;
                        if (cnt_q == 9'd1) begin
                            state_d = IDLE;
                        end
                    end
                end else if (to_q == TO_LAST) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end

            RREQ: begin
                wait_d  = WAIT_LOAD;
                state_d = RWAIT;
            end

            RWAIT: begin
                // Latch as the counter reaches zero so tx_valid rises RD_LATENCY+1 after RREQ.
                wait_d = wait_q - 1'b1;
                if (wait_q <= WAIT_W'(1)) begin
                    tx_data_d  = bus.data_out_b;
                    tx_valid_d = 1'b1;
                    state_d    = RSEND;
                end
            end

            RSEND: begin
                if (tx_valid_q && bus.tx_ready) begin
                    tx_valid_d = 1'b0;
                    addr_d     = addr_q + 1'b1;
                    cnt_d      = cnt_q - 9'd1;
                    state_d    = (cnt_q == 9'd1) ? IDLE : RREQ;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            cnt_q      <= '0;
            is_read_q  <= 1'b0;
            wait_q     <= '0;
            to_q       <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            data_in_q  <= '0;
            wr_en_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            is_read_q  <= is_read_d;
            wait_q     <= wait_d;
            to_q       <= to_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            data_in_q  <= data_in_d;
            wr_en_q    <= wr_en_d;
            err_q      <= err_d;
        end
    end

    assign bus.addr_b    = addr_q;
    assign bus.data_in_b = data_in_q;
    assign bus.wr_en_b   = wr_en_q;
    assign bus.tx_data   = tx_data_q;
    assign bus.tx_valid  = tx_valid_q;
    assign busy          = (state_q != IDLE);
    assign err           = err_q;

endmodule
`default_nettype wire

// File: tb/tb_gpu_rs232_ram_bridge.sv
`default_nettype none
// ============================================================================
// Module  : tb_gpu_rs232_ram_bridge
// Purpose : Directed self-checking bench with a port-B RAM model and tx sink.
// Revision: 1.0 - initial release
// ============================================================================
module tb_gpu_rs232_ram_bridge;

    localparam int ADDR_W = 20;
    localparam int RD_LAT = 2;
    localparam int TO     = 40;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy;
    logic err;

    always #5 clk = ~clk;

    gpu_rs232_ram_bridge_if #(.ADDR_W(ADDR_W)) bus ();

    gpu_rs232_ram_bridge #(
        .ADDR_W         (ADDR_W),
        .RD_LATENCY     (RD_LAT),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .busy  (busy),
        .err   (err)
    );

    // Port-B RAM: registered address and registered data, two clocks of latency.
    bit   [7:0]        mem [0:(1<<ADDR_W)-1];
    logic [ADDR_W-1:0] ram_addr_q;
    always @(posedge clk) begin
        if (bus.wr_en_b) mem[bus.addr_b] <= bus.data_in_b;
        ram_addr_q     <= bus.addr_b;
        bus.data_out_b <= mem[ram_addr_q];
    end

    int checks = 0;
    int errors = 0;

    logic [ADDR_W-1:0] wr_addr_q [$];
    logic [7:0]        wr_data_q [$];
    logic [7:0]        tx_q      [$];
    int   err_cnt   = 0;
    int   stab_err  = 0;
    int   stall_cfg = 0;
    int   stall_cnt = 0;
    logic prev_v = 1'b0, prev_r = 1'b0;
    logic [7:0] prev_d = 8'h00;

    // Monitor and tx sink, both acting on the falling edge.
    initial begin
        bus.tx_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.wr_en_b === 1'b1) begin
                wr_addr_q.push_back(bus.addr_b);
                wr_data_q.push_back(bus.data_in_b);
            end
            if (err === 1'b1) err_cnt++;
            if (prev_v && !prev_r && bus.tx_valid && bus.tx_data !== prev_d) stab_err++;
            prev_v = bus.tx_valid;
            prev_d = bus.tx_data;
            if (bus.tx_valid !== 1'b1) begin
                bus.tx_ready = 1'b0;
                stall_cnt    = 0;
            end else if (stall_cnt >= stall_cfg) begin
                bus.tx_ready = 1'b1;
                tx_q.push_back(bus.tx_data);
            end else begin
                stall_cnt++;
            end
            prev_r = bus.tx_ready;
        end
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
    endtask

    task automatic idle_rx();
        @(negedge clk);
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
    endtask

    task automatic clear_logs();
        wr_addr_q.delete();
        wr_data_q.delete();
        tx_q.delete();
        err_cnt  = 0;
        stab_err = 0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        while (busy !== 1'b0 && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s idle: busy=%b after %0d cycles, required 0", name, busy, n);
        end
    endtask

    task automatic wait_tx(input int cnt, input int budget, input string name);
        int n = 0;
        while (tx_q.size() < cnt && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (tx_q.size() < cnt) begin
            errors++;
            $display("FAIL %s tx_count: got %0d bytes, required %0d", name, tx_q.size(), cnt);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        checks += 7;
        if (bus.addr_b !== 20'h0)   begin errors++; $display("FAIL %s addr_b: %h required 00000", name, bus.addr_b); end
        if (bus.data_in_b !== 8'h0) begin errors++; $display("FAIL %s data_in_b: %h required 00", name, bus.data_in_b); end
        if (bus.wr_en_b !== 1'b0)   begin errors++; $display("FAIL %s wr_en_b: %b required 0", name, bus.wr_en_b); end
        if (bus.tx_valid !== 1'b0)  begin errors++; $display("FAIL %s tx_valid: %b required 0", name, bus.tx_valid); end
        if (bus.tx_data !== 8'h0)   begin errors++; $display("FAIL %s tx_data: %h required 00", name, bus.tx_data); end
        if (busy !== 1'b0)          begin errors++; $display("FAIL %s busy: %b required 0", name, busy); end
        if (err !== 1'b0)           begin errors++; $display("FAIL %s err: %b required 0", name, err); end
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        tick(3);
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_write();
        logic [ADDR_W-1:0] ea [3] = '{20'h00100, 20'h00101, 20'h00102};
        logic [7:0]        ed [3] = '{8'hAA, 8'hBB, 8'hCC};
        clear_logs();
        send(8'h57); send(8'h00); #1;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL write busy_mid: %b required 1", busy); end
        send(8'h01); send(8'h00); send(8'h03); send(8'hAA); send(8'hBB); #1;
        checks += 3;
        if (bus.wr_en_b !== 1'b1)    begin errors++; $display("FAIL write wr_en_n1: %b required 1", bus.wr_en_b); end
        if (bus.data_in_b !== 8'hAA) begin errors++; $display("FAIL write data_n1: %h required AA", bus.data_in_b); end
        if (bus.addr_b !== 20'h00100) begin errors++; $display("FAIL write addr_n1: %h required 00100", bus.addr_b); end
        send(8'hCC); #1;
        checks += 2;
        if (bus.data_in_b !== 8'hBB) begin errors++; $display("FAIL write data_n2: %h required BB", bus.data_in_b); end
        if (bus.addr_b !== 20'h00101) begin errors++; $display("FAIL write addr_n2: %h required 00101", bus.addr_b); end
        idle_rx();
        wait_idle(20, "write");
        tick(3);
        checks++;
        if (wr_addr_q.size() != 3) begin errors++; $display("FAIL write count: %0d required 3", wr_addr_q.size()); end
        for (int i = 0; i < 3 && i < wr_addr_q.size(); i++) begin
            checks += 2;
            if (wr_addr_q[i] !== ea[i]) begin errors++; $display("FAIL write addr[%0d]: %h required %h", i, wr_addr_q[i], ea[i]); end
            if (wr_data_q[i] !== ed[i]) begin errors++; $display("FAIL write data[%0d]: %h required %h", i, wr_data_q[i], ed[i]); end
        end
    endtask

    task automatic test_read_stall();
        logic [7:0] ed [3] = '{8'hAA, 8'hBB, 8'hCC};
        int n = 0;
        clear_logs();
        stall_cfg = 5;
        send(8'h52); send(8'h00); send(8'h01); send(8'h00); send(8'h03);
        idle_rx(); #1;
        while (bus.tx_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (n != RD_LAT + 1) begin errors++; $display("FAIL read latency: tx_valid after %0d cycles, required %0d", n, RD_LAT + 1); end
        wait_tx(3, 300, "read");
        wait_idle(50, "read");
        tick(5);
        checks += 2;
        if (tx_q.size() != 3) begin errors++; $display("FAIL read count: %0d required 3", tx_q.size()); end
        if (stab_err != 0) begin errors++; $display("FAIL read stable: %0d tx_data changes while stalled, required 0", stab_err); end
        for (int i = 0; i < 3 && i < tx_q.size(); i++) begin
            checks++;
            if (tx_q[i] !== ed[i]) begin errors++; $display("FAIL read byte[%0d]: %h required %h", i, tx_q[i], ed[i]); end
        end
        stall_cfg = 0;
    endtask

    task automatic test_wrap();
        clear_logs();
        send(8'h57); send(8'h0F); send(8'hFF); send(8'hFF); send(8'h02); send(8'h11); send(8'h22);
        idle_rx();
        wait_idle(20, "wrap_w");
        tick(3);
        checks++;
        if (wr_addr_q.size() != 2) begin errors++; $display("FAIL wrap count: %0d required 2", wr_addr_q.size()); end
        if (wr_addr_q.size() == 2) begin
            checks += 4;
            if (wr_addr_q[0] !== 20'hFFFFF) begin errors++; $display("FAIL wrap addr0: %h required FFFFF", wr_addr_q[0]); end
            if (wr_data_q[0] !== 8'h11)     begin errors++; $display("FAIL wrap data0: %h required 11", wr_data_q[0]); end
            if (wr_addr_q[1] !== 20'h00000) begin errors++; $display("FAIL wrap addr1: %h required 00000", wr_addr_q[1]); end
            if (wr_data_q[1] !== 8'h22)     begin errors++; $display("FAIL wrap data1: %h required 22", wr_data_q[1]); end
        end
        clear_logs();
        send(8'h52); send(8'h0F); send(8'hFF); send(8'hFF); send(8'h02);
        idle_rx();
        wait_tx(2, 100, "wrap_r");
        wait_idle(50, "wrap_r");
        tick(3);
        checks++;
        if (tx_q.size() != 2) begin errors++; $display("FAIL wrap rd_count: %0d required 2", tx_q.size()); end
        if (tx_q.size() == 2) begin
            checks += 2;
            if (tx_q[0] !== 8'h11) begin errors++; $display("FAIL wrap rd0: %h required 11", tx_q[0]); end
            if (tx_q[1] !== 8'h22) begin errors++; $display("FAIL wrap rd1: %h required 22", tx_q[1]); end
        end
    endtask

    task automatic test_len256();
        logic [7:0] b;
        clear_logs();
        send(8'h57); send(8'h00); send(8'h20); send(8'h00); send(8'h00);
        for (int i = 0; i < 256; i++) begin
            b = 8'(i * 7 + 3);
            send(b);
        end
        idle_rx();
        wait_idle(20, "len256_w");
        tick(3);
        checks++;
        if (wr_addr_q.size() != 256) begin errors++; $display("FAIL len256 wr_count: %0d required 256", wr_addr_q.size()); end
        if (wr_addr_q.size() == 256) begin
            checks += 2;
            if (wr_addr_q[0] !== 20'h02000)   begin errors++; $display("FAIL len256 first_addr: %h required 02000", wr_addr_q[0]); end
            if (wr_addr_q[255] !== 20'h020FF) begin errors++; $display("FAIL len256 last_addr: %h required 020FF", wr_addr_q[255]); end
        end
        clear_logs();
        send(8'h52); send(8'h00); send(8'h20); send(8'h00); send(8'h00);
        idle_rx();
        wait_tx(256, 256 * 10, "len256_r");
        wait_idle(50, "len256_r");
        tick(10);
        checks++;
        if (tx_q.size() != 256) begin errors++; $display("FAIL len256 rd_count: %0d required 256", tx_q.size()); end
        for (int i = 0; i < 256 && i < tx_q.size(); i++) begin
            b = 8'(i * 7 + 3);
            checks++;
            if (tx_q[i] !== b) begin errors++; $display("FAIL len256 rd[%0d]: %h required %h", i, tx_q[i], b); end
        end
    endtask

    task automatic test_bad_header();
        clear_logs();
        send(8'h41);
        idle_rx();
        tick(3);
        checks += 2;
        if (err_cnt != 1) begin errors++; $display("FAIL badhdr err_pulses: %0d required 1", err_cnt); end
        if (busy !== 1'b0) begin errors++; $display("FAIL badhdr busy: %b required 0", busy); end
        send(8'h57); send(8'h00); send(8'h03); send(8'h00); send(8'h01); send(8'h5C);
        idle_rx();
        wait_idle(20, "badhdr");
        tick(3);
        checks += 2;
        if (wr_addr_q.size() != 1) begin errors++; $display("FAIL badhdr wr_count: %0d required 1", wr_addr_q.size()); end
        if (err_cnt != 1) begin errors++; $display("FAIL badhdr err_after: %0d required 1", err_cnt); end
        if (wr_addr_q.size() == 1) begin
            checks += 2;
            if (wr_addr_q[0] !== 20'h00300) begin errors++; $display("FAIL badhdr addr: %h required 00300", wr_addr_q[0]); end
            if (wr_data_q[0] !== 8'h5C)     begin errors++; $display("FAIL badhdr data: %h required 5C", wr_data_q[0]); end
        end
    endtask

    task automatic test_timeout();
        clear_logs();
        send(8'h57); send(8'h00); send(8'h00);
        idle_rx();
        tick(TO / 2);
        checks += 2;
        if (busy !== 1'b1) begin errors++; $display("FAIL timeout busy_wait: %b required 1", busy); end
        if (err_cnt != 0)  begin errors++; $display("FAIL timeout early_err: %0d required 0", err_cnt); end
        tick(TO);
        checks += 3;
        if (err_cnt != 1)          begin errors++; $display("FAIL timeout err_pulses: %0d required 1", err_cnt); end
        if (busy !== 1'b0)         begin errors++; $display("FAIL timeout busy: %b required 0", busy); end
        if (wr_addr_q.size() != 0) begin errors++; $display("FAIL timeout writes: %0d required 0", wr_addr_q.size()); end
        send(8'h57); send(8'h00); send(8'h04); send(8'h00); send(8'h01); send(8'h77);
        idle_rx();
        wait_idle(20, "timeout");
        tick(3);
        checks++;
        if (wr_addr_q.size() != 1) begin errors++; $display("FAIL timeout next_count: %0d required 1", wr_addr_q.size()); end
        if (wr_addr_q.size() == 1) begin
            checks += 2;
            if (wr_addr_q[0] !== 20'h00400) begin errors++; $display("FAIL timeout next_addr: %h required 00400", wr_addr_q[0]); end
            if (wr_data_q[0] !== 8'h77)     begin errors++; $display("FAIL timeout next_data: %h required 77", wr_data_q[0]); end
        end
    endtask

    task automatic test_reset_mid();
        clear_logs();
        send(8'h57); send(8'h00); send(8'h05); send(8'h00); send(8'h04); send(8'h11);
        @(negedge clk);
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        rst_n        = 1'b0;
        settle();
        check_reset_outputs("rst_mid");
        @(negedge clk);
        rst_n = 1'b1;
        send(8'h57); send(8'h00); send(8'h06); send(8'h00); send(8'h01); send(8'h99);
        idle_rx();
        wait_idle(20, "rst_mid");
        tick(3);
        checks++;
        if (wr_addr_q.size() != 2) begin errors++; $display("FAIL rst_mid wr_count: %0d required 2", wr_addr_q.size()); end
        if (wr_addr_q.size() == 2) begin
            checks += 4;
            if (wr_addr_q[0] !== 20'h00500) begin errors++; $display("FAIL rst_mid addr0: %h required 00500", wr_addr_q[0]); end
            if (wr_data_q[0] !== 8'h11)     begin errors++; $display("FAIL rst_mid data0: %h required 11", wr_data_q[0]); end
            if (wr_addr_q[1] !== 20'h00600) begin errors++; $display("FAIL rst_mid addr1: %h required 00600", wr_addr_q[1]); end
            if (wr_data_q[1] !== 8'h99)     begin errors++; $display("FAIL rst_mid data1: %h required 99", wr_data_q[1]); end
        end
    endtask

    initial begin
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        test_reset();
        test_write();
        test_read_stall();
        test_wrap();
        test_len256();
        test_bad_header();
        test_timeout();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
